// File: rtl/ledhex_decode_if.sv
// ledhex_decode_if: segment bus plus decoded-result signals for ledhex_decode.
//   hex       : NSEG*7 active-low segment bus, digit i at [7i+6:7i], segment a at bit 7i
//   value     : decoded binary value of the last snapshot
//   valid     : one-cycle pulse when value/err/err_digit update
//   err       : last snapshot contained an illegal digit pattern
//   err_digit : index of the highest illegal digit (0 if none)
//   busy      : decoder is walking the digits of a snapshot
// master drives the bus and observes results; slave is the decoder.
interface ledhex_decode_if #(
    parameter int unsigned NSEG = 8
);
    logic [NSEG*7-1:0] hex;
    logic [31:0]       value;
    logic              valid;
    logic              err;
    logic [3:0]        err_digit;
    logic              busy;

    modport master (
        output hex,
        input  value, valid, err, err_digit, busy
    );

    modport slave (
        input  hex,
        output value, valid, err, err_digit, busy
    );
endinterface

// File: rtl/ledhex_decode.sv
// ledhex_decode: reads back an 8-digit active-low 7-segment bus once it is stable,
// decodes it most significant digit first and reports the binary value.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : ledhex_decode_if.slave (hex in; value, valid, err, err_digit, busy out)
module ledhex_decode #(
    parameter int unsigned NSEG          = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic           clk,
    input logic           rst_n,
    ledhex_decode_if.slave bus
);
    localparam int unsigned W = NSEG * 7;
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic [0:0] {StWait, StDecode} state_e;

    state_e       state_q;
    logic [W-1:0] hex_q;
    logic [W-1:0] snap_q;
    logic [W-1:0] last_q;
    logic         have_snap_q;
    logic [7:0]   cnt_q;
    logic [31:0]  acc_q;
    logic [3:0]   idx_q;
    logic         err_acc_q;
    logic [3:0]   err_idx_q;
    logic [31:0]  value_q;
    logic         valid_q;
    logic         err_q;
    logic [3:0]   err_digit_q;
    logic         busy_q;

    logic [6:0]   cur_pat;
    logic [3:0]   cur_dig;
    logic         cur_bad;
    logic [31:0]  acc_next;

    // Digit under decode; blank decodes to 0 without flagging an error.
    always_comb begin
        cur_pat = snap_q[7*idx_q +: 7];
        cur_dig = 4'd0;
        cur_bad = 1'b0;
        case (cur_pat)
            7'b1000000: cur_dig = 4'd0;
            7'b1111001: cur_dig = 4'd1;
            7'b0100100: cur_dig = 4'd2;
            7'b0110000: cur_dig = 4'd3;
            7'b0011001: cur_dig = 4'd4;
            7'b0010010: cur_dig = 4'd5;
            7'b0000010: cur_dig = 4'd6;
            7'b1111000: cur_dig = 4'd7;
            7'b0000000: cur_dig = 4'd8;
            7'b0010000: cur_dig = 4'd9;
            7'b1111111: cur_dig = 4'd0;
            default:    cur_bad = 1'b1;
        endcase
        acc_next = acc_q * 32'd10 + {28'd0, cur_dig};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StWait;
            hex_q       <= '1;
            snap_q      <= '1;
            last_q      <= '1;
            have_snap_q <= 1'b0;
            cnt_q       <= 8'd0;
            acc_q       <= 32'd0;
            idx_q       <= 4'd0;
            err_acc_q   <= 1'b0;
            err_idx_q   <= 4'd0;
            value_q     <= 32'd0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= 4'd0;
            busy_q      <= 1'b0;
        end else begin
            // Stability counter runs in every state so a new pattern can queue up during DECODE.
            hex_q <= bus.hex;
            if (bus.hex != hex_q) begin
                cnt_q <= 8'd0;
            end else if (cnt_q != STABLE) begin
                cnt_q <= cnt_q + 8'd1;
            end

            valid_q <= 1'b0;

            case (state_q)
                StWait: begin
                    if (cnt_q == STABLE && (!have_snap_q || hex_q != last_q)) begin
                        snap_q    <= hex_q;
                        acc_q     <= 32'd0;
                        idx_q     <= 4'(NSEG - 1);
                        err_acc_q <= 1'b0;
                        err_idx_q <= 4'd0;
                        busy_q    <= 1'b1;
                        state_q   <= StDecode;
                    end
                end
                StDecode: begin
                    acc_q <= acc_next;
                    // MSB-first walk: the first illegal digit seen is the highest one.
                    if (cur_bad && !err_acc_q) begin
                        err_acc_q <= 1'b1;
                        err_idx_q <= idx_q;
                    end
                    if (idx_q == 4'd0) begin
                        value_q     <= acc_next;
                        err_q       <= err_acc_q | cur_bad;
                        err_digit_q <= err_acc_q ? err_idx_q : 4'd0;
                        valid_q     <= 1'b1;
                        last_q      <= snap_q;
                        have_snap_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StWait;
                    end else begin
                        idx_q <= idx_q - 4'd1;
                    end
                end
                default: state_q <= StWait;
            endcase
        end
    end

    assign bus.value     = value_q;
    assign bus.valid     = valid_q;
    assign bus.err       = err_q;
    assign bus.err_digit = err_digit_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ledhex_decode.sv
// tb_ledhex_decode: directed self-checking bench for ledhex_decode (NSEG=8, STABLE_CYCLES=4).
module tb_ledhex_decode;
    localparam int unsigned NSEG = 8;
    localparam int unsigned S    = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ledhex_decode_if #(.NSEG(NSEG)) bus ();

    ledhex_decode #(
        .NSEG          (NSEG),
        .STABLE_CYCLES (S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int unsigned d);
        case (d)
            0: seg = 7'b1000000;
            1: seg = 7'b1111001;
            2: seg = 7'b0100100;
            3: seg = 7'b0110000;
            4: seg = 7'b0011001;
            5: seg = 7'b0010010;
            6: seg = 7'b0000010;
            7: seg = 7'b1111000;
            8: seg = 7'b0000000;
            9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    function automatic logic [NSEG*7-1:0] num_pat(input int unsigned n);
        logic [NSEG*7-1:0] p;
        int unsigned m;
        m = n;
        for (int i = 0; i < NSEG; i++) begin
            p[i*7 +: 7] = seg(m % 10);
            m = m / 10;
        end
        return p;
    endfunction

    // Counts edges (sampled #1 after each) until valid is seen; -1 on timeout.
    task automatic wait_valid(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic count_valids(input int ncyc, output int nv);
        nv = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid) nv++;
        end
    endtask

    task automatic test_reset();
        int c;
        int nv;
        bus.hex = '1;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.value !== 32'd0 || bus.valid !== 1'b0 || bus.err !== 1'b0 ||
            bus.err_digit !== 4'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: value=%0d valid=%b err=%b err_digit=%0d busy=%b, want all 0",
                     bus.value, bus.valid, bus.err, bus.err_digit, bus.busy);
        end
        rst_n = 1'b1;
        wait_valid(40, c);
        n_checks++;
        if (c !== 13) begin
            n_fail++;
            $display("FAIL reset_blank_latency: got %0d edges, want 13", c);
        end
        n_checks++;
        if (bus.value !== 32'd0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_blank_value: value=%0d err=%b, want 0/0", bus.value, bus.err);
        end
        count_valids(30, nv);
        n_checks++;
        if (nv !== 0) begin
            n_fail++;
            $display("FAIL reset_blank_hold: %0d extra valids, want 0", nv);
        end
    endtask

    task automatic test_basic();
        int c;
        int nv;
        bus.hex = num_pat(12345678);
        wait_valid(40, c);
        n_checks++;
        if (c !== S + 2 + NSEG) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges, want %0d", c, S + 2 + NSEG);
        end
        n_checks++;
        if (bus.value !== 32'd12345678 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_value: value=%0d err=%b busy=%b, want 12345678/0/0",
                     bus.value, bus.err, bus.busy);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse_width: valid=%b one cycle later, want 0", bus.valid);
        end
        bus.hex = num_pat(12345678);
        count_valids(30, nv);
        n_checks++;
        if (nv !== 0) begin
            n_fail++;
            $display("FAIL basic_redrive: %0d valids, want 0", nv);
        end
    endtask

    task automatic test_glitch();
        int c;
        int nv;
        logic [NSEG*7-1:0] p;
        bus.hex = num_pat(42);
        wait_valid(40, c);
        n_checks++;
        if (c !== S + 2 + NSEG || bus.value !== 32'd42) begin
            n_fail++;
            $display("FAIL glitch_setup: edges=%0d value=%0d, want %0d/42", c, bus.value,
                     S + 2 + NSEG);
        end
        p = num_pat(42);
        p[21 +: 7] = 7'b0000000;
        bus.hex = p;
        count_valids(3, nv);
        bus.hex = num_pat(42);
        count_valids(30, c);
        nv = nv + c;
        n_checks++;
        if (nv !== 0 || bus.value !== 32'd42) begin
            n_fail++;
            $display("FAIL glitch_ignored: valids=%0d value=%0d, want 0/42", nv, bus.value);
        end
    endtask

    task automatic test_error();
        int c;
        logic [NSEG*7-1:0] p;
        // Shows 0 8 X 0 0 X 4 2 with illegal digits 5 and 2.
        p = num_pat(8000042);
        p[35 +: 7] = 7'b1010101;
        p[14 +: 7] = 7'b1010101;
        bus.hex = p;
        wait_valid(40, c);
        n_checks++;
        if (c < 0 || bus.err !== 1'b1 || bus.err_digit !== 4'd5 || bus.value !== 32'd8000042) begin
            n_fail++;
            $display("FAIL error_digit: edges=%0d err=%b err_digit=%0d value=%0d, want 1/5/8000042",
                     c, bus.err, bus.err_digit, bus.value);
        end
        bus.hex = num_pat(99999999);
        wait_valid(40, c);
        n_checks++;
        if (c < 0 || bus.err !== 1'b0 || bus.err_digit !== 4'd0 || bus.value !== 32'd99999999) begin
            n_fail++;
            $display("FAIL error_clear: edges=%0d err=%b err_digit=%0d value=%0d, want 0/0/99999999",
                     c, bus.err, bus.err_digit, bus.value);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int b;
        bus.hex = num_pat(22222222);
        b = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) begin
                b = i;
                break;
            end
        end
        n_checks++;
        if (b !== S + 2) begin
            n_fail++;
            $display("FAIL b2b_busy_rise: busy after %0d edges, want %0d", b, S + 2);
        end
        @(posedge clk);
        #1;
        bus.hex = num_pat(11111111);
        wait_valid(40, c);
        n_checks++;
        if (c < 0 || bus.value !== 32'd22222222) begin
            n_fail++;
            $display("FAIL b2b_first: edges=%0d value=%0d, want 22222222", c, bus.value);
        end
        wait_valid(40, c);
        n_checks++;
        if (c !== NSEG + 1 || bus.value !== 32'd11111111) begin
            n_fail++;
            $display("FAIL b2b_second: edges=%0d value=%0d, want %0d/11111111", c, bus.value,
                     NSEG + 1);
        end
    endtask

    task automatic test_mid_reset();
        int c;
        int b;
        bus.hex = num_pat(12121212);
        b = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) begin
                b = i;
                break;
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (b < 0 || bus.value !== 32'd0 || bus.valid !== 1'b0 || bus.err !== 1'b0 ||
            bus.err_digit !== 4'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: busy_seen=%0d value=%0d valid=%b err=%b busy=%b, want 0s",
                     b, bus.value, bus.valid, bus.err, bus.busy);
        end
        rst_n = 1'b1;
        wait_valid(40, c);
        n_checks++;
        if (c !== S + 2 + NSEG || bus.value !== 32'd12121212) begin
            n_fail++;
            $display("FAIL midreset_redecode: edges=%0d value=%0d, want %0d/12121212", c,
                     bus.value, S + 2 + NSEG);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.hex  = '1;
        test_reset();
        test_basic();
        test_glitch();
        test_error();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
